// File: rtl/iter_mult_unit_if.sv
// Handshake bundle between the execute stage and the iterative multiplier.
// master drives the operands and start; slave returns status and the HI/LO product.
interface iter_mult_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/iter_mult_unit.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied unsigned over WIDTH steps,
// then the sign is applied in a single fix-up cycle before HI/LO are updated.
module iter_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  iter_mult_unit_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} stateE;

  stateE              stateQ, stateD;
  logic [WIDTH-1:0]   mcandQ, mcandD;
  logic [WIDTH-1:0]   mplierQ, mplierD;
  logic [WIDTH-1:0]   accQ, accD;
  logic [CntW-1:0]    cntQ, cntD;
  logic               negQ, negD;
  logic               busyQ, busyD;
  logic               doneQ, doneD;
  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;

  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] signedProd;

  // Negating -2^(WIDTH-1) yields itself, which is the correct unsigned magnitude.
  assign magA       = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB       = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign sum        = {1'b0, accQ} + {1'b0, (mplierQ[0] ? mcandQ : '0)};
  assign prod       = {accQ, mplierQ};
  assign signedProd = negQ ? -prod : prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      cntQ    <= '0;
      negQ    <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
    end else begin
      stateQ  <= stateD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
      cntQ    <= cntD;
      negQ    <= negD;
      busyQ   <= busyD;
      doneQ   <= doneD;
      hiQ     <= hiD;
      loQ     <= loD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    accD    = accQ;
    cntD    = cntQ;
    negD    = negQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          stateD  = StRun;
          mcandD  = magA;
          mplierD = magB;
          accD    = '0;
          cntD    = CntW'(WIDTH - 1);
          negD    = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end
      end
      StRun: begin
        // Shift the carry/acc/mplier chain right by one.
        accD    = sum[WIDTH:1];
        mplierD = {sum[0], mplierQ[WIDTH-1:1]};
        cntD    = cntQ - CntW'(1);
        if (cntQ == '0) begin
          stateD = StFix;
        end
      end
      StFix: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_comb begin
    busyD = (stateD != StIdle);
    doneD = (stateQ == StFix);
    hiD   = hiQ;
    loD   = loQ;
    if (stateQ == StFix) begin
      hiD = signedProd[2*WIDTH-1:WIDTH];
      loD = signedProd[WIDTH-1:0];
    end
  end

  assign bus.busy = busyQ;
  assign bus.done = doneQ;
  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;

endmodule

// File: tb/tb_iter_mult_unit.sv
// Scoreboard bench for iter_mult_unit: stimulus queues expected products, a negedge
// monitor checks value, latency and busy length on every done pulse.
module tb_iter_mult_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iter_mult_unit_if #(.WIDTH(W)) bus ();

  iter_mult_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int          nCompared = 0;
  int          nMismatch = 0;
  longint      cyc = 0;
  int          busyRun = 0;
  logic [63:0] expQ[$];
  longint      issueQ[$];
  logic [63:0] mExp;
  longint      mIssue;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      busyRun = 0;
    end else begin
      if (bus.busy) busyRun++;
      if (bus.done) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, expected no done",
                   bus.hi, bus.lo);
        end else begin
          mExp   = expQ.pop_front();
          mIssue = issueQ.pop_front();
          check("product", {bus.hi, bus.lo}, mExp);
          check("latency", 64'(cyc - mIssue), 64'd34);
          check("busy_cycles", 64'(busyRun), 64'd33);
          check("busy_at_done", 64'(bus.busy), 64'd0);
        end
        busyRun = 0;
      end
    end
  end

  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sign  = sg;
    bus.a     = a;
    bus.b     = b;
    expQ.push_back(exp);
    issueQ.push_back(cyc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatch++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", expQ.size());
      expQ.delete();
      issueQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // T1 unsigned max * max
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    drain(60);
    // T2 signed
    issue(1'b1, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    drain(60);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    drain(60);
    // T3 most-negative squared, signed and unsigned
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    drain(60);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    drain(60);

    // T4 start while busy is ignored; hi/lo hold during RUN
    issue(1'b0, 32'd7, 32'd6, 64'd42);
    check("hold_hi_in_run", 64'(bus.hi), 64'h4000_0000);
    check("hold_lo_in_run", 64'(bus.lo), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_op", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain(60);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_ignored", 64'(bus.busy), 64'd0);
    check("result_kept", {bus.hi, bus.lo}, 64'd42);

    // T5 reset mid-op
    issue(1'b0, 32'd7, 32'd6, 64'd42);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    issueQ.delete();
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(1'b0, 32'd2, 32'd3, 64'd6);
    drain(60);

    // T6 back-to-back: new start in the done cycle
    issue(1'b0, 32'd5, 32'd5, 64'd25);
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 60) begin
        @(posedge clk);
        #1;
        n++;
        if (bus.done) seen = 1'b1;
      end
      if (seen) begin
        bus.start = 1'b1;
        bus.sign  = 1'b0;
        bus.a     = 32'd4;
        bus.b     = 32'd4;
        expQ.push_back(64'd16);
        issueQ.push_back(cyc);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end else begin
        nCompared++;
        nMismatch++;
        $display("FAIL b2b_done_timeout: got no done, expected done within 60 cycles");
      end
    end
    drain(60);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
